// File: rtl/data_rx.sv
// Receive-side frame decoder: hunts for a sync byte, collects a fixed payload,
// verifies an XOR checksum and publishes the payload with a one-cycle strobe.
module data_rx #(
    parameter int unsigned PAYLOAD_BYTES  = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter int unsigned LINK_CYCLES    = 10_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_empty,
    input  logic [7:0]                 r_data,
    output logic                       rd_uart,
    output logic [8*PAYLOAD_BYTES-1:0] data_out,
    output logic                       data_valid,
    output logic                       frame_err,
    output logic [7:0]                 err_count,
    output logic                       link_up
);

    localparam int unsigned W     = 8 * PAYLOAD_BYTES;
    localparam int unsigned IDX_W = (PAYLOAD_BYTES  > 1) ? $clog2(PAYLOAD_BYTES)  : 1;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LNK_W = (LINK_CYCLES    > 1) ? $clog2(LINK_CYCLES)    : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LNK_W-1:0] LNK_MAX  = LNK_W'(LINK_CYCLES - 1);

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_t;

    state_t           state;
    logic [W-1:0]     pbuf;
    logic [7:0]       csum;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] tmr;
    logic [LNK_W-1:0] lnk_cnt;
    logic             byte_in;

    // Every state consumes, so the FIFO is never stalled.
    assign byte_in = !rx_empty;
    assign rd_uart = byte_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            pbuf       <= '0;
            csum       <= '0;
            idx        <= '0;
            tmr        <= '0;
            lnk_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            link_up    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (lnk_cnt != LNK_MAX) begin
                lnk_cnt <= lnk_cnt + LNK_W'(1);
            end else begin
                link_up <= 1'b0;
            end

            // Stall timer only runs inside a frame on cycles without a byte.
            if (state != HUNT && !byte_in) begin
                if (tmr == TMR_MAX) begin
                    frame_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                    state <= HUNT;
                end else begin
                    tmr <= tmr + TMR_W'(1);
                end
            end

            case (state)
                HUNT: begin
                    if (byte_in && r_data == SYNC_BYTE) begin
                        csum  <= SYNC_BYTE;
                        idx   <= '0;
                        tmr   <= '0;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (byte_in) begin
                        pbuf <= (pbuf << 8) | W'(r_data);
                        csum <= csum ^ r_data;
                        tmr  <= '0;
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (byte_in) begin
                        tmr   <= '0;
                        state <= HUNT;
                        // A good frame overrides the watchdog update made above.
                        if (r_data == csum) begin
                            data_out   <= pbuf;
                            data_valid <= 1'b1;
                            link_up    <= 1'b1;
                            lnk_cnt    <= '0;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_data_rx.sv
// Self-checking bench for data_rx: byte-stream reference model compared every
// cycle, plus directed frames with hand-computed expectations.
module tb_data_rx;

    localparam int unsigned P    = 4;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam int unsigned T    = 50;
    localparam int unsigned L    = 1000;

    logic           clk = 1'b0;
    logic           rst;
    logic           rx_empty;
    logic [7:0]     r_data;
    logic           rd_uart;
    logic [8*P-1:0] data_out;
    logic           data_valid;
    logic           frame_err;
    logic [7:0]     err_count;
    logic           link_up;

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes of the frame being collected, idle streak,
    // cycles since the last good frame.
    bit             in_frame;
    logic [7:0]     fq[$];
    int             idle;
    int             since;
    logic [8*P-1:0] m_data;
    logic [7:0]     m_err;
    bit             m_valid;
    bit             m_ferr;

    always #5 clk = ~clk;

    data_rx #(
        .PAYLOAD_BYTES (P),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(T),
        .LINK_CYCLES   (L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .err_count (err_count),
        .link_up   (link_up)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        in_frame = 0;
        fq.delete();
        idle    = 0;
        since   = L;
        m_data  = '0;
        m_err   = '0;
        m_valid = 0;
        m_ferr  = 0;
    endfunction

    function automatic void model_bad();
        m_ferr   = 1;
        m_err    = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        in_frame = 0;
    endfunction

    function automatic void model_step();
        logic [7:0] x;
        m_valid = 0;
        m_ferr  = 0;
        if (!rx_empty) begin
            if (!in_frame) begin
                if (r_data == SYNC) begin
                    in_frame = 1;
                    fq.delete();
                    idle = 0;
                end
            end else begin
                idle = 0;
                if (fq.size() < P) begin
                    fq.push_back(r_data);
                end else begin
                    x = SYNC;
                    foreach (fq[i]) x ^= fq[i];
                    if (x == r_data) begin
                        for (int i = 0; i < P; i++) m_data[8*(P-1-i) +: 8] = fq[i];
                        m_valid  = 1;
                        in_frame = 0;
                    end else begin
                        model_bad();
                    end
                end
            end
        end else if (in_frame) begin
            idle++;
            if (idle == T) model_bad();
        end
        if (m_valid) since = 0;
        else if (since < L) since++;
    endfunction

    task automatic compare_all();
        chk("data_out",   64'(data_out),   64'(m_data));
        chk("data_valid", 64'(data_valid), 64'(m_valid));
        chk("frame_err",  64'(frame_err),  64'(m_ferr));
        chk("err_count",  64'(err_count),  64'(m_err));
        chk("link_up",    64'(link_up),    64'(since < L));
        chk("rd_uart",    64'(rd_uart),    64'(!rx_empty));
    endtask

    task automatic cyc(input bit e, input logic [7:0] b);
        rx_empty = e;
        r_data   = e ? 8'($urandom) : b;
        @(posedge clk);
        model_step();
        #1 compare_all();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cyc(1'b1, 8'h00);
    endtask

    task automatic send_frame(input logic [8*P-1:0] pl, input bit corrupt,
                              input int max_gap, input bit stall);
        logic [7:0] bytes[$];
        logic [7:0] cs;
        logic [7:0] b;
        int         stall_pos;
        cs = SYNC;
        bytes.push_back(SYNC);
        for (int i = 0; i < P; i++) begin
            b = pl[8*(P-1-i) +: 8];
            bytes.push_back(b);
            cs ^= b;
        end
        if (corrupt) cs ^= 8'(1 << $urandom_range(0, 7));
        bytes.push_back(cs);
        stall_pos = $urandom_range(1, P + 1);
        foreach (bytes[i]) begin
            if (stall && i == stall_pos) idle_cycles(T + 3);
            else idle_cycles($urandom_range(0, max_gap));
            cyc(1'b0, bytes[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] g;
        rst      = 1'b0;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        model_reset();
        #2;
        chk("rst_data_out",   64'(data_out),   64'h0);
        chk("rst_err_count",  64'(err_count),  64'h0);
        chk("rst_data_valid", 64'(data_valid), 64'h0);
        chk("rst_frame_err",  64'(frame_err),  64'h0);
        chk("rst_link_up",    64'(link_up),    64'h0);
        chk("rst_rd_uart_e",  64'(rd_uart),    64'h0);
        rx_empty = 1'b0;
        #1 chk("rst_rd_uart_ne", 64'(rd_uart), 64'h1);
        rx_empty = 1'b1;
        #20 rst = 1'b1;

        // Clean frame; checksum covers the sync byte: A5^11^22^33^44 = E1.
        cyc(0, 8'hA5); cyc(0, 8'h11); cyc(0, 8'h22); cyc(0, 8'h33); cyc(0, 8'h44);
        cyc(0, 8'hE1);
        chk("clean_data",  64'(data_out),   64'h11223344);
        chk("clean_valid", 64'(data_valid), 64'h1);
        chk("clean_link",  64'(link_up),    64'h1);
        chk("clean_errs",  64'(err_count),  64'h0);
        cyc(1, 8'h00);
        chk("clean_valid_drop", 64'(data_valid), 64'h0);

        // Garbage, then a back-to-back frame: A5^DE^AD^BE^EF = 87.
        cyc(0, 8'h00); cyc(0, 8'hFF); cyc(0, 8'h5A);
        cyc(0, 8'hA5); cyc(0, 8'hDE); cyc(0, 8'hAD); cyc(0, 8'hBE); cyc(0, 8'hEF);
        cyc(0, 8'h87);
        chk("garbage_data", 64'(data_out),  64'hDEADBEEF);
        chk("garbage_errs", 64'(err_count), 64'h0);

        // Bad checksum (correct value would be A1).
        cyc(0, 8'hA5); cyc(0, 8'h01); cyc(0, 8'h02); cyc(0, 8'h03); cyc(0, 8'h04);
        cyc(0, 8'h00);
        chk("bad_ferr",  64'(frame_err),  64'h1);
        chk("bad_valid", 64'(data_valid), 64'h0);
        chk("bad_errs",  64'(err_count),  64'h1);
        chk("bad_data",  64'(data_out),   64'hDEADBEEF);

        // T-1 idle cycles then a byte: the byte wins, frame still good.
        cyc(0, 8'hA5); cyc(0, 8'h01);
        idle_cycles(T - 1);
        chk("edge_no_ferr", 64'(frame_err), 64'h0);
        cyc(0, 8'h02); cyc(0, 8'h03); cyc(0, 8'h04); cyc(0, 8'hA1);
        chk("edge_data", 64'(data_out), 64'h01020304);

        // Stall for T cycles mid-frame.
        cyc(0, 8'hA5); cyc(0, 8'h01); cyc(0, 8'h02);
        idle_cycles(T - 1);
        chk("stall_early", 64'(frame_err), 64'h0);
        idle_cycles(1);
        chk("stall_ferr", 64'(frame_err), 64'h1);
        chk("stall_errs", 64'(err_count), 64'h2);
        send_frame(32'hCAFE0123, 0, 0, 0);
        chk("after_stall_data", 64'(data_out), 64'hCAFE0123);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    g = 8'($urandom);
                    if (g == SYNC) g = 8'h00;
                    cyc(0, g);
                end
            end
            send_frame(32'($urandom), $urandom_range(0, 4) == 0, 3,
                       $urandom_range(0, 14) == 0);
        end

        // Error counter saturation.
        repeat (300) send_frame(32'($urandom), 1, 0, 0);
        chk("sat_errs", 64'(err_count), 64'hFF);
        send_frame(32'($urandom), 1, 0, 0);
        chk("sat_hold", 64'(err_count), 64'hFF);

        // Link watchdog: high for exactly L cycles after a good frame.
        send_frame(32'h0BADF00D, 0, 0, 0);
        chk("wd_link_rise", 64'(link_up), 64'h1);
        for (int k = 1; k <= L; k++) begin
            cyc(1, 8'h00);
            if (k == L - 1) chk("wd_link_before", 64'(link_up), 64'h1);
            if (k == L)     chk("wd_link_drop",   64'(link_up), 64'h0);
        end
        idle_cycles(5);

        // Async reset mid-payload.
        send_frame(32'h55667788, 0, 0, 0);
        cyc(0, 8'hA5); cyc(0, 8'h01); cyc(0, 8'h02);
        rx_empty = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_data_out",   64'(data_out),   64'h0);
        chk("arst_err_count",  64'(err_count),  64'h0);
        chk("arst_data_valid", 64'(data_valid), 64'h0);
        chk("arst_frame_err",  64'(frame_err),  64'h0);
        chk("arst_link_up",    64'(link_up),    64'h0);
        chk("arst_rd_uart",    64'(rd_uart),    64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        cyc(0, 8'hA5); cyc(0, 8'h11); cyc(0, 8'h22); cyc(0, 8'h33); cyc(0, 8'h44);
        cyc(0, 8'hE1);
        chk("post_rst_data",  64'(data_out),   64'h11223344);
        chk("post_rst_valid", 64'(data_valid), 64'h1);
        idle_cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
